stream_mem_bridge: RTL and testbench

Parametrised single-clock bridge between a host AXI4-Stream pair (din/dout) and the processor-local BRAMs. The host programs a command register. The block streams N words into or out of a selected processor memory starting at a given address. When the address wraps past a bank boundary, the block advances automatically to the next processor. It adds three capabilities: a programmable transfer length, a read path that tolerates memory read latency and backpressure through a credit FIFO, and TLAST framing-error reporting.

---
 rtl/stream_mem_bridge_if.sv | 29 ++
 rtl/stream_mem_bridge.sv | 145 ++++++++++++++
 tb/tb_stream_mem_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mem_bridge_if.sv
// stream_mem_bridge_if: host AXI-Stream pair plus processor BRAM bus seen by the bridge
interface stream_mem_bridge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 60,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_PROC   = 8,
  parameter int PSEL_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
);
  logic                    din_TVALID, din_TREADY, din_TLAST;
  logic [DATA_WIDTH-1:0]   din_TDATA;
  logic [DATA_WIDTH/8-1:0] din_TSTRB;
  logic                    dout_TVALID, dout_TREADY, dout_TLAST;
  logic [DATA_WIDTH-1:0]   dout_TDATA;
  logic [DATA_WIDTH/8-1:0] dout_TSTRB;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WORD_WIDTH-1:0]   mem_wdata, mem_rdata;
  logic                    mem_we, mem_re, mem_bcast, mem_intr;
  logic [PSEL_W-1:0]       mem_psel;
  modport master (
    input  din_TVALID, din_TLAST, din_TDATA, din_TSTRB, dout_TREADY, mem_rdata,
    output din_TREADY, dout_TVALID, dout_TLAST, dout_TDATA, dout_TSTRB,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_psel, mem_bcast, mem_intr
  );
  modport slave (
    output din_TVALID, din_TLAST, din_TDATA, din_TSTRB, dout_TREADY, mem_rdata,
    input  din_TREADY, dout_TVALID, dout_TLAST, dout_TDATA, dout_TSTRB,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_psel, mem_bcast, mem_intr
  );
endinterface

// File: rtl/stream_mem_bridge.sv
// stream_mem_bridge: streams N words between host AXI-Stream and processor BRAMs, with credit-based read return
module stream_mem_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 60,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_PROC   = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] Command0,
  input  logic [31:0] Command1,
  output logic [31:0] Status0,
  stream_mem_bridge_if.master bus
);
  localparam int PSEL_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WR, RD, RELEASE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PSEL_W-1:0]     psel_q, psel_d;
  logic                  bcast_q, bcast_d, done_rd_q, done_rd_d, done_wr_q, done_wr_d, err_q, err_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, iss_q, iss_d;
  logic [CRED_W-1:0]     cred_q, cred_d, fcnt_q, fcnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [WORD_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]            op;
  logic                  start, wr_beat, last_beat, issue, push, pop, unused_bits;
  assign op        = Command0[31:24];
  assign start     = (op == 8'd1 || op == 8'd2) && Command1[LEN_WIDTH-1:0] != '0;
  assign wr_beat   = state_q == WR && bus.din_TVALID;
  assign last_beat = cnt_q == len_q - LEN_WIDTH'(1);
  assign issue     = state_q == RD && iss_q < len_q && cred_q != '0;
  assign push      = vld_q[RD_LATENCY-1];
  assign pop       = fcnt_q != '0 && bus.dout_TREADY;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    psel_d    = psel_q;
    bcast_d   = bcast_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_rd_d = done_rd_q;
    done_wr_d = done_wr_q;
    fifo_d    = fifo_q;
    iss_d     = iss_q + LEN_WIDTH'(issue);
    vld_d     = (vld_q << 1) | RD_LATENCY'(issue);
    cred_d    = cred_q - CRED_W'(issue) + CRED_W'(pop);
    fcnt_d    = fcnt_q + CRED_W'(push) - CRED_W'(pop);
    wptr_d    = push ? (wptr_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d    = pop ? (rptr_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : rptr_q + PTR_W'(1)) : rptr_q;
    if (push) fifo_d[wptr_q] = bus.mem_rdata;
    // a broadcast write keeps every processor selected, so the bank never advances
    if (wr_beat || issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (&addr_q && !bcast_q) psel_d = psel_q == PSEL_W'(NUM_PROC - 1) ? '0 : psel_q + PSEL_W'(1);
    end
    case (state_q)
      IDLE: if (start) begin
        state_d   = op == 8'd1 ? WR : RD;
        addr_d    = Command0[ADDR_WIDTH-1:0];
        psel_d    = PSEL_W'(32'(Command0[23:20]) % NUM_PROC);
        bcast_d   = op == 8'd1 && Command0[16];
        len_d     = Command1[LEN_WIDTH-1:0];
        cnt_d     = '0;
        iss_d     = '0;
        err_d     = 1'b0;
        done_wr_d = done_wr_q && op != 8'd1;
        done_rd_d = done_rd_q && op != 8'd2;
      end
      WR: if (wr_beat) begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
        if (last_beat || bus.din_TLAST) begin
          state_d   = RELEASE;
          done_wr_d = 1'b1;
          err_d     = bus.din_TLAST != last_beat;
        end
      end
      RD: if (pop) begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
        if (last_beat) begin
          state_d   = RELEASE;
          done_rd_d = 1'b1;
        end
      end
      RELEASE: if (op == 8'd0) state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    fifo_q <= fifo_d;
    if (!ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      psel_q    <= '0;
      bcast_q   <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      iss_q     <= '0;
      err_q     <= 1'b0;
      done_rd_q <= 1'b1;
      done_wr_q <= 1'b1;
      cred_q    <= CRED_W'(FIFO_DEPTH);
      fcnt_q    <= '0;
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      psel_q    <= psel_d;
      bcast_q   <= bcast_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      iss_q     <= iss_d;
      err_q     <= err_d;
      done_rd_q <= done_rd_d;
      done_wr_q <= done_wr_d;
      cred_q    <= cred_d;
      fcnt_q    <= fcnt_d;
      vld_q     <= vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end
  assign bus.din_TREADY  = state_q == WR;
  assign bus.mem_we      = wr_beat;
  assign bus.mem_re      = issue;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = bus.din_TDATA[WORD_WIDTH-1:0];
  assign bus.mem_psel    = psel_q;
  assign bus.mem_bcast   = bcast_q;
  assign bus.mem_intr    = state_q != IDLE;
  assign bus.dout_TVALID = fcnt_q != '0;
  assign bus.dout_TLAST  = fcnt_q != '0 && last_beat;
  assign bus.dout_TDATA  = DATA_WIDTH'(fifo_q[rptr_q]);
  assign bus.dout_TSTRB  = '1;
  assign Status0         = {15'd0, done_rd_q, 14'd0, err_q, done_wr_q};
  assign unused_bits     = ^{Command0, Command1, bus.din_TDATA, bus.din_TSTRB};
endmodule

// File: tb/tb_stream_mem_bridge.sv
// tb_stream_mem_bridge: randomized self-checking bench with a BRAM responder and address/data reference model
module tb_stream_mem_bridge;
  localparam int DW = 64, WW = 60, AW = 11, NP = 8, LW = 16, RL = 2, FD = 4, PW = 3;
  localparam int BANK = 1 << AW;
  typedef struct packed {
    logic [PW-1:0] psel;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          bcast;
  } wr_t;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [31:0] cmd0 = '0, cmd1 = '0, status;
  int          vectors = 0, miscompares = 0;
  wr_t                 wr_log[$];
  logic [PW+AW-1:0]    re_log[$];
  logic [WW:0]         rx_log[$];
  logic [WW-1:0]       sent_q[$];
  logic [WW-1:0]       rd_pipe [RL];
  int                  out_cnt = 0, over_cnt = 0, hold_err = 0;
  logic                prev_stall = 1'b0;
  logic [DW-1:0]       prev_data = '0;
  stream_mem_bridge_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_PROC(NP)) bus();
  stream_mem_bridge #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_PROC(NP),
                      .LEN_WIDTH(LW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .ACLK(clk), .ARESETN(rstn), .Command0(cmd0), .Command1(cmd1), .Status0(status), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [WW-1:0] mem_word(input logic [PW-1:0] p, input logic [AW-1:0] a);
    logic [63:0] x;
    x = (64'({p, a}) + 64'd1) * 64'h9E37_79B9_7F4A_7C15;
    return x[WW-1:0];
  endfunction
  // BRAM responder returning data RL cycles after each read strobe, plus bus monitors
  assign bus.mem_rdata = rd_pipe[RL-1];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= bus.mem_re ? mem_word(bus.mem_psel, bus.mem_addr) : '0;
    if (bus.mem_we) wr_log.push_back({bus.mem_psel, bus.mem_addr, bus.mem_wdata, bus.mem_bcast});
    if (bus.mem_re) re_log.push_back({bus.mem_psel, bus.mem_addr});
    if (bus.dout_TVALID && bus.dout_TREADY) rx_log.push_back({bus.dout_TLAST, bus.dout_TDATA[WW-1:0]});
    out_cnt = out_cnt + int'(bus.mem_re);
    if (out_cnt > FD) over_cnt++;
    if (bus.dout_TVALID && bus.dout_TREADY) out_cnt--;
    if (prev_stall && (!bus.dout_TVALID || bus.dout_TDATA !== prev_data)) hold_err++;
    prev_stall = bus.dout_TVALID && !bus.dout_TREADY;
    prev_data  = bus.dout_TDATA;
    if (!rstn) begin
      out_cnt    = 0;
      prev_stall = 1'b0;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic release_cmd();
    cmd0 = '0;
    cyc(2);
  endtask
  task automatic drive_write(input int nbeats, input int last_at, input int stall_pct);
    int   i = 0, guard = 0;
    logic v, rdy;
    sent_q.delete();
    while (i < nbeats && guard < 1000) begin
      v = $urandom_range(99) >= stall_pct;
      bus.din_TVALID = v;
      bus.din_TDATA  = {$urandom, $urandom};
      bus.din_TLAST  = i == last_at;
      rdy = bus.din_TREADY;
      @(negedge clk);
      if (v && rdy) begin
        sent_q.push_back(bus.din_TDATA[WW-1:0]);
        i++;
      end
      guard++;
    end
    bus.din_TVALID = 1'b0;
    bus.din_TLAST  = 1'b0;
    vectors++;
    if (i !== nbeats) begin
      miscompares++;
      $display("FAIL wr_accept: %0d beats taken, required %0d", i, nbeats);
    end
  endtask
  task automatic test_write_xfer(input int proc, input logic bc, input int addr, input int len,
                                 input int last_at, input int stall_pct, input string name);
    int   wb = wr_log.size();
    int   k  = (last_at >= 0 && last_at < len) ? last_at + 1 : len;
    logic exp_err = last_at != len - 1;
    wr_t  exp;
    int   n;
    cmd1 = 32'(len);
    cmd0 = {8'd1, 4'(proc), 3'b000, bc, 16'(addr)};
    cyc(1);
    vectors++;
    if (status[0] !== 1'b0 || bus.mem_intr !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_start: done_write=%b intr=%b, required 0 1", name, status[0], bus.mem_intr);
    end
    drive_write(k, last_at, stall_pct);
    vectors++;
    if (bus.din_TREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_tready: din_TREADY=%b after last beat, required 0", name, bus.din_TREADY);
    end
    vectors++;
    if (status !== {15'd0, 1'b1, 14'd0, exp_err, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_status: Status0=%h, required %h", name, status, {15'd0, 1'b1, 14'd0, exp_err, 1'b1});
    end
    n = wr_log.size() - wb;
    vectors++;
    if (n !== k) begin
      miscompares++;
      $display("FAIL %s_nwe: %0d mem_we, required %0d", name, n, k);
    end
    for (int i = 0; i < k && i < n && i < sent_q.size(); i++) begin
      exp.psel  = bc ? PW'(proc % NP) : PW'((proc % NP + (addr + i) / BANK) % NP);
      exp.addr  = AW'((addr + i) % BANK);
      exp.data  = sent_q[i];
      exp.bcast = bc;
      vectors++;
      if (wr_log[wb+i] !== exp) begin
        miscompares++;
        $display("FAIL %s_we%0d: got psel/addr/data/bc %h, required %h", name, i, wr_log[wb+i], exp);
      end
    end
    cyc(1);
    release_cmd();
  endtask
  task automatic test_read_xfer(input int proc, input logic bc, input int addr, input int len,
                                input int mode, input string name);
    int rb = rx_log.size(), qb = re_log.size(), hb = hold_err, ob = over_cnt;
    int pat[4] = '{1, 0, 0, 1};
    int cnt = 0, n;
    logic [PW-1:0] ep;
    logic [AW-1:0] ea;
    logic [WW:0]   er;
    cmd1 = 32'(len);
    cmd0 = {8'd2, 4'(proc), 3'b000, bc, 16'(addr)};
    cyc(1);
    vectors++;
    if (status[16] !== 1'b0 || bus.mem_bcast !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_start: done_read=%b bcast=%b, required 0 0", name, status[16], bus.mem_bcast);
    end
    while (rx_log.size() - rb < len && cnt < 20 * len + 50) begin
      bus.dout_TREADY = mode == 0 ? 1'b1 : mode == 1 ? 1'(pat[cnt % 4]) : 1'($urandom_range(1));
      @(negedge clk);
      cnt++;
    end
    bus.dout_TREADY = 1'b1;
    cyc(3);
    n = rx_log.size() - rb;
    vectors++;
    if (n !== len) begin
      miscompares++;
      $display("FAIL %s_nwords: %0d words delivered, required %0d", name, n, len);
    end
    vectors++;
    if (re_log.size() - qb !== len) begin
      miscompares++;
      $display("FAIL %s_nre: %0d mem_re, required %0d", name, re_log.size() - qb, len);
    end
    for (int i = 0; i < len; i++) begin
      ep = PW'((proc % NP + (addr + i) / BANK) % NP);
      ea = AW'((addr + i) % BANK);
      er = {i == len - 1, mem_word(ep, ea)};
      if (i < n) begin
        vectors++;
        if (rx_log[rb+i] !== er) begin
          miscompares++;
          $display("FAIL %s_word%0d: got last/data %h, required %h", name, i, rx_log[rb+i], er);
        end
      end
      if (i < re_log.size() - qb) begin
        vectors++;
        if (re_log[qb+i] !== {ep, ea}) begin
          miscompares++;
          $display("FAIL %s_re%0d: got psel/addr %h, required %h", name, i, re_log[qb+i], {ep, ea});
        end
      end
    end
    vectors++;
    if (status[16] !== 1'b1 || bus.mem_intr !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: done_read=%b intr=%b, required 1 1", name, status[16], bus.mem_intr);
    end
    vectors++;
    if (hold_err - hb !== 0 || over_cnt - ob !== 0) begin
      miscompares++;
      $display("FAIL %s_flow: %0d unstable stalls, %0d credit overruns, required 0 0", name, hold_err - hb, over_cnt - ob);
    end
    if (mode == 0) begin
      vectors++;
      if (cnt > len + RL + 2) begin
        miscompares++;
        $display("FAIL %s_rate: %0d cycles for %0d words, required <= %0d", name, cnt, len, len + RL + 2);
      end
    end
    release_cmd();
  endtask
  task automatic test_reset();
    bus.din_TVALID  = 1'b0;
    bus.din_TLAST   = 1'b0;
    bus.din_TDATA   = '0;
    bus.din_TSTRB   = '1;
    bus.dout_TREADY = 1'b1;
    rstn = 1'b0;
    cyc(3);
    rstn = 1'b1;
    cyc(1);
    vectors++;
    if (status !== 32'h0001_0001) begin
      miscompares++;
      $display("FAIL reset_status: Status0=%h, required 00010001", status);
    end
    vectors++;
    if ({bus.din_TREADY, bus.dout_TVALID, bus.mem_we, bus.mem_re, bus.mem_bcast, bus.mem_intr} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: rdy/vld/we/re/bc/intr=%b, required 000000",
               {bus.din_TREADY, bus.dout_TVALID, bus.mem_we, bus.mem_re, bus.mem_bcast, bus.mem_intr});
    end
    vectors++;
    if (bus.mem_addr !== '0 || bus.mem_psel !== '0 || bus.dout_TSTRB !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h psel=%h strb=%h, required 0 0 ff", bus.mem_addr, bus.mem_psel, bus.dout_TSTRB);
    end
  endtask
  task automatic test_idle_hold();
    cmd1 = 32'd0;
    cmd0 = {8'd1, 4'd2, 4'd0, 16'h0010};
    cyc(3);
    vectors++;
    if (bus.mem_intr !== 1'b0 || status !== 32'h0001_0001) begin
      miscompares++;
      $display("FAIL len_zero: intr=%b Status0=%h, required 0 00010001", bus.mem_intr, status);
    end
    cmd1 = 32'd5;
    cmd0 = {8'd3, 4'd2, 4'd0, 16'h0010};
    cyc(3);
    vectors++;
    if (bus.mem_intr !== 1'b0 || bus.din_TREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_opcode: intr=%b tready=%b, required 0 0", bus.mem_intr, bus.din_TREADY);
    end
    release_cmd();
  endtask
  task automatic test_write();
    test_write_xfer(2, 1'b0, 'h010, 4, 3, 0, "write");
  endtask
  task automatic test_wrap_read();
    test_read_xfer(7, 1'b0, 'h7FE, 4, 0, "wrap_read");
  endtask
  task automatic test_backpressure();
    test_read_xfer(3, 1'b0, 'h100, 16, 1, "backpressure");
  endtask
  task automatic test_frame_err();
    test_write_xfer(4, 1'b0, 'h200, 8, 4, 20, "frame_early");
    test_write_xfer(1, 1'b0, 'h300, 3, -1, 0, "frame_missing");
  endtask
  task automatic test_bcast();
    test_write_xfer(5, 1'b1, 'h7FF, 2, 1, 0, "bcast");
  endtask
  task automatic test_reset_mid_read();
    int rb = rx_log.size(), qb, guard = 0;
    bus.dout_TREADY = 1'b1;
    cmd1 = 32'd16;
    cmd0 = {8'd2, 4'd1, 4'd0, 16'h07F0};
    while (rx_log.size() - rb < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rstn = 1'b0;
    cmd0 = '0;
    @(negedge clk);
    rstn = 1'b1;
    vectors++;
    if (status !== 32'h0001_0001 || bus.mem_intr !== 1'b0 || bus.dout_TVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: Status0=%h intr=%b vld=%b, required 00010001 0 0", status, bus.mem_intr, bus.dout_TVALID);
    end
    qb = re_log.size();
    cyc(10);
    vectors++;
    if (re_log.size() !== qb) begin
      miscompares++;
      $display("FAIL midreset_re: %0d mem_re after reset, required 0", re_log.size() - qb);
    end
    test_write_xfer(1, 1'b0, 'h020, 3, 2, 30, "post_reset");
  endtask
  task automatic test_random();
    int proc, addr, len, sel, last_at;
    for (int t = 0; t < 14; t++) begin
      proc = $urandom_range(15);
      addr = $urandom_range(1) ? BANK - 1 - int'($urandom_range(6)) : int'($urandom_range(BANK - 1));
      len  = $urandom_range(12, 1);
      if ($urandom_range(1) == 1) begin
        sel     = $urandom_range(2);
        last_at = sel == 0 ? len - 1 : sel == 1 ? int'($urandom_range(len - 1)) : -1;
        test_write_xfer(proc, 1'($urandom_range(1)), addr, len, last_at, 25, "rand_wr");
      end else begin
        test_read_xfer(proc, 1'($urandom_range(1)), addr, len, 2, "rand_rd");
      end
    end
  endtask
  initial begin
    test_reset();
    test_idle_hold();
    test_write();
    test_wrap_read();
    test_backpressure();
    test_frame_err();
    test_bcast();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
